lcd_serial_sink: RTL and testbench
==================================

LCD_SERIAL_SINK -- requirements
Module: lcd_serial_sink

Interface
REQ-001 Parameter: COL_LAST, default 127, meaning last column index before the column counter wraps to 0.
REQ-002 Parameter: PAGE_BITS, default 3, meaning width of the page address; 8 pages at the default.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 sys_clk  input  1  system clock (12 MHz); all logic on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 sck  input  1  LCD serial clock, synchronous to sys_clk.
REQ-007 sda  input  1  serial data or command bit, MSB first.
REQ-008 rs  input  1  register select: 1 = display data, 0 = command.
REQ-009 cs  input  1  chip select, active low.
REQ-010 byte_valid  output  1  one-cycle pulse when a byte completes.
REQ-011 byte_out  output  8  last completed byte.
REQ-012 byte_is_data  output  1  rs value captured with the last byte.
REQ-013 pix_we  output  1  one-cycle write strobe for a display-data byte.
REQ-014 pix_addr  output  PAGE_BITS+7  {page, column} of the data byte.
REQ-015 pix_data  output  8  data byte to be written.
REQ-016 disp_on  output  1  display on/off state set by command.
REQ-017 cmd_count  output  8  number of command bytes received; saturates at 255.
REQ-018 frame_err  output  1  sticky flag for a partial byte aborted by cs.

Function
REQ-019 The block SHALL detect a sample point as any cycle with cs==0, sck==1, and registered previous sck==0.
REQ-020 At each sample point the block SHALL shift sda into an 8-bit register, MSB first, and increment the 3-bit bit counter.
REQ-021 The FSM SHALL have two states, IDLE (cs high) and SHIFT (cs low); it moves IDLE->SHIFT on cs==0 and SHIFT->IDLE on cs==1.
REQ-022 On the 8th sample the block SHALL, on the next cycle, pulse byte_valid and update byte_out and byte_is_data (rs sampled at the 8th bit).
REQ-023 After the 8th sample the block SHALL reset the bit counter to 0 and stay in SHIFT, so back-to-back bytes under one cs-low window are accepted.
REQ-024 If cs rises with the bit counter at 1..7, the block SHALL discard the partial byte, set frame_err, and emit no byte_valid.
REQ-025 No sample SHALL be taken in a cycle where cs==1, even if sck rises in that cycle.
REQ-026 Command decode (byte_is_data==0) SHALL be:
  - 1011_xxxx: page <= byte[PAGE_BITS-1:0].
  - 0001_xxxx: column[6:4] <= byte[2:0].
  - 0000_xxxx: column[3:0] <= byte[3:0].
  - 0xAE: disp_on <= 0.
  - 0xAF: disp_on <= 1.
  - any other command: counted only, no other effect.
REQ-027 Every command byte SHALL increment cmd_count, saturating at 255.
REQ-028 A data byte SHALL pulse pix_we in the same cycle as byte_valid, with pix_addr = current {page, column} and pix_data = byte.
REQ-029 After each data byte the column SHALL increment on the next cycle; COL_LAST+1 SHALL wrap to 0 and the page SHALL stay unchanged.
REQ-030 Address changes SHALL take effect for the first data byte that completes after the command byte.

Reset
REQ-031 While reset is high, the block SHALL hold state=IDLE, bit counter=0, shift register=0, byte_out=0, byte_is_data=0, byte_valid=0, pix_we=0, pix_addr=0, pix_data=0, disp_on=0, cmd_count=0, frame_err=0, and previous sck=0.
REQ-032 Reset asserted mid-byte SHALL abort the byte without setting frame_err, and the first byte after reset SHALL be received normally.
REQ-033 frame_err SHALL be cleared only by reset.

Verification
REQ-034 Send command 0xB3, then 0x12, then 0x05, then data 0x5A, using sck toggling every cycle -> exactly one pix_we pulse with pix_addr = {3'd3, 7'd37} and pix_data = 0x5A; cmd_count = 3.
REQ-035 Set column 127, then send two data bytes 0x01 and 0x02 -> pix_addr columns 127 then 0, page unchanged.
REQ-036 Send four command bytes back-to-back under one cs-low window -> four byte_valid pulses, each 1 cycle wide, spaced 8 sample points apart.
REQ-037 Raise cs after 5 bits -> frame_err = 1, no byte_valid; the next full byte 0xAF is still received and sets disp_on = 1.
REQ-038 Assert reset after 4 bits, then release it and send 0xA5 as data -> byte_out = 0xA5, frame_err = 0, and all other outputs at reset values before the byte.
REQ-039 Send 300 command bytes -> cmd_count holds at 255.

Source files
------------

// File: rtl/lcd_serial_sink.sv
// lcd_serial_sink: receives the serial LCD controller stream (sck/sda/rs/cs),
// assembles bytes MSB first, decodes page/column/display commands and emits
// pixel write strobes for display-data bytes.
//
// state | meaning
// IDLE  | cs high, bit counter held at 0
// SHIFT | cs low, sampling sda on sck rising edges
module lcd_serial_sink #(
  parameter int COL_LAST  = 127,
  parameter int PAGE_BITS = 3
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 sda,
  input  logic                 rs,
  input  logic                 cs,
  output logic                 byte_valid,
  output logic [7:0]           byte_out,
  output logic                 byte_is_data,
  output logic                 pix_we,
  output logic [PAGE_BITS+6:0] pix_addr,
  output logic [7:0]           pix_data,
  output logic                 disp_on,
  output logic [7:0]           cmd_count,
  output logic                 frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic                 sck_q;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic [PAGE_BITS-1:0] page;
  logic [6:0]           col;
  logic                 sample;
  logic [7:0]           next_byte;

  // Sample point: rising sck seen while selected; the byte includes the current bit.
  always_comb begin
    sample    = !cs && sck && !sck_q;
    next_byte = {shreg[6:0], sda};
  end

  // Receiver FSM, byte assembly, command decode and pixel strobe generation.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= IDLE;
      sck_q        <= 1'b0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'd0;
      page         <= '0;
      col          <= 7'd0;
      byte_valid   <= 1'b0;
      byte_out     <= 8'd0;
      byte_is_data <= 1'b0;
      pix_we       <= 1'b0;
      pix_addr     <= '0;
      pix_data     <= 8'd0;
      disp_on      <= 1'b0;
      cmd_count    <= 8'd0;
      frame_err    <= 1'b0;
    end else begin
      sck_q      <= sck;
      byte_valid <= 1'b0;
      pix_we     <= 1'b0;

      case (state)
        IDLE:    if (!cs) state <= SHIFT;
        SHIFT:   if (cs)  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (cs) begin
        // Deselect mid-byte drops the partial byte and latches the error.
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
        bit_cnt <= 3'd0;
      end else if (sample) begin
        shreg <= next_byte;
        if (bit_cnt == 3'd7) begin
          bit_cnt      <= 3'd0;
          byte_valid   <= 1'b1;
          byte_out     <= next_byte;
          byte_is_data <= rs;
          if (rs) begin
            pix_we   <= 1'b1;
            pix_addr <= {page, col};
            pix_data <= next_byte;
            col      <= (col == COL_LAST[6:0]) ? 7'd0 : col + 7'd1;
          end else begin
            if (cmd_count != 8'hFF) cmd_count <= cmd_count + 8'd1;
            if (next_byte[7:4] == 4'b1011)      page     <= next_byte[PAGE_BITS-1:0];
            else if (next_byte[7:4] == 4'b0001) col[6:4] <= next_byte[2:0];
            else if (next_byte[7:4] == 4'b0000) col[3:0] <= next_byte[3:0];
            else if (next_byte == 8'hAE)        disp_on  <= 1'b0;
            else if (next_byte == 8'hAF)        disp_on  <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_serial_sink.sv
// tb_lcd_serial_sink: directed and random serial streams against a
// byte-level reference model of the LCD command/data semantics.
module tb_lcd_serial_sink;

  localparam int COL_LAST  = 127;
  localparam int PAGE_BITS = 3;

  logic                 sys_clk = 1'b0;
  logic                 reset, sck, sda, rs, cs;
  logic                 byte_valid, byte_is_data, pix_we, disp_on, frame_err;
  logic [7:0]           byte_out, pix_data, cmd_count;
  logic [PAGE_BITS+6:0] pix_addr;

  lcd_serial_sink #(.COL_LAST(COL_LAST), .PAGE_BITS(PAGE_BITS)) dut (
    .sys_clk(sys_clk), .reset(reset), .sck(sck), .sda(sda), .rs(rs), .cs(cs),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_is_data(byte_is_data),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .disp_on(disp_on), .cmd_count(cmd_count), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_page, m_col, m_disp, m_cnt, m_ferr;

  // output monitor
  int cyc = 0, bv_count = 0, pw_count = 0, wide = 0, last_bv = -1;
  logic bv_prev = 1'b0;
  int spacing[$];

  always @(negedge sys_clk) begin
    cyc++;
    if (byte_valid) begin
      bv_count++;
      if (last_bv >= 0) spacing.push_back(cyc - last_bv);
      last_bv = cyc;
    end
    if (byte_valid && bv_prev) wide++;
    bv_prev = byte_valid;
    if (pix_we) pw_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    m_page = 0; m_col = 0; m_disp = 0; m_cnt = 0; m_ferr = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) begin
      sda = v[7 - i];
      sck = 1'b0;
      step();
      sck = 1'b1;
      step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    int bv0, pw0, exp_addr, hi;
    cs  = 1'b0;
    rs  = d;
    bv0 = bv_count;
    pw0 = pw_count;
    exp_addr = m_page * 128 + m_col;
    send_bits(b, 8);
    chk("byte_valid", {31'd0, byte_valid}, 32'd1);
    chk("byte_out", {24'd0, byte_out}, {24'd0, b});
    chk("byte_is_data", {31'd0, byte_is_data}, {31'd0, d});
    chk("pix_we", {31'd0, pix_we}, {31'd0, d});
    if (d) begin
      chk("pix_addr", {22'd0, pix_addr}, exp_addr);
      chk("pix_data", {24'd0, pix_data}, {24'd0, b});
      m_col = (m_col == COL_LAST) ? 0 : m_col + 1;
    end else begin
      if (m_cnt < 255) m_cnt++;
      hi = int'(b) / 16;
      if (hi == 11)      m_page = int'(b) % (1 << PAGE_BITS);
      else if (hi == 1)  m_col = (m_col % 16) + (int'(b) % 8) * 16;
      else if (hi == 0)  m_col = (m_col / 16) * 16 + int'(b) % 16;
      else if (b == 8'hAE) m_disp = 0;
      else if (b == 8'hAF) m_disp = 1;
    end
    chk("disp_on", {31'd0, disp_on}, m_disp);
    chk("cmd_count", {24'd0, cmd_count}, m_cnt);
    chk("frame_err", {31'd0, frame_err}, m_ferr);
    #1;
    chk("bv_pulses", bv_count - bv0, 1);
    chk("pw_pulses", pw_count - pw0, {31'd0, d});
  endtask

  task automatic abort_byte(input logic [7:0] b, input int n);
    int bv0;
    bv0 = bv_count;
    cs = 1'b0;
    rs = 1'b0;
    send_bits(b, n);
    chk("abort_no_bv", {31'd0, byte_valid}, 32'd0);
    cs  = 1'b1;
    sck = 1'b0;
    step();
    step();
    m_ferr = 1;
    chk("abort_ferr", {31'd0, frame_err}, 32'd1);
    chk("abort_bv_cnt", bv_count - bv0, 0);
  endtask

  initial begin
    int pw0, bv0, r, n;
    logic [7:0] rb;

    reset = 1'b1; cs = 1'b1; sck = 1'b0; sda = 1'b0; rs = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_bv", {31'd0, byte_valid}, 32'd0);
    chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
    chk("rst_pix_addr", {22'd0, pix_addr}, 32'd0);
    chk("rst_cmd_count", {24'd0, cmd_count}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    step();

    // page 3, column 37, one data byte
    pw0 = pw_count;
    send_byte(8'hB3, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("req34_addr", {22'd0, pix_addr}, 32'd421);
    chk("req34_cnt", {24'd0, cmd_count}, 32'd3);
    step();
    chk("req34_pw_once", pw_count - pw0, 1);
    cs = 1'b1;
    step();

    // column wrap at COL_LAST
    send_byte(8'h17, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h01, 1'b1);
    chk("req35_col127", {22'd0, pix_addr}, 32'd511);
    send_byte(8'h02, 1'b1);
    chk("req35_col0", {22'd0, pix_addr}, 32'd384);

    // four back-to-back bytes in one cs-low window
    step();
    last_bv = -1;
    spacing.delete();
    wide = 0;
    bv0 = bv_count;
    for (int i = 0; i < 4; i++) send_byte(8'hE3, 1'b0);
    step();
    chk("req36_count", bv_count - bv0, 4);
    chk("req36_width", wide, 0);
    chk("req36_nspace", spacing.size(), 3);
    foreach (spacing[i]) chk("req36_space", spacing[i], 16);
    cs = 1'b1;
    step();

    // sck edges while deselected are ignored
    for (int i = 0; i < 4; i++) begin
      sck = ~sck; sda = ~sda; step();
    end
    sck = 1'b0;
    step();
    send_byte(8'h3C, 1'b0);

    // partial byte aborted by cs, then a good byte
    abort_byte(8'hFF, 5);
    send_byte(8'hAF, 1'b0);
    chk("req37_disp", {31'd0, disp_on}, 32'd1);
    chk("req37_ferr", {31'd0, frame_err}, 32'd1);

    // reset mid-byte
    cs = 1'b0;
    rs = 1'b1;
    send_bits(8'hC3, 4);
    sck = 1'b0;
    reset = 1'b1;
    step();
    step();
    model_reset();
    chk("req38_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("req38_rst_disp", {31'd0, disp_on}, 32'd0);
    chk("req38_rst_out", {24'd0, byte_out}, 32'd0);
    chk("req38_rst_cnt", {24'd0, cmd_count}, 32'd0);
    chk("req38_rst_we", {31'd0, pix_we}, 32'd0);
    reset = 1'b0;
    step();
    send_byte(8'hA5, 1'b1);
    chk("req38_ferr", {31'd0, frame_err}, 32'd0);
    chk("req38_addr", {22'd0, pix_addr}, 32'd0);

    // random mix of commands, data, aborts and deselect gaps
    for (int k = 0; k < 150; k++) begin
      r  = int'($urandom_range(0, 9));
      rb = 8'($urandom);
      if (r == 0) begin
        n = int'($urandom_range(1, 7));
        abort_byte(rb, n);
      end else if (r == 1) begin
        cs = 1'b1;
        for (int i = 0; i < 3; i++) begin
          sck = ~sck; step();
        end
        sck = 1'b0;
        step();
      end else begin
        send_byte(rb, 1'($urandom));
      end
    end

    // command counter saturation
    model_reset();
    reset = 1'b1;
    cs = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 300; i++) send_byte(8'hE3, 1'b0);
    chk("req39_sat", {24'd0, cmd_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
